perf_counter_ctrl: RTL

PERF_COUNTER_CTRL -- requirements
Module: perf_counter_ctrl

---
 rtl/perf_counter_ctrl_if.sv | 22 ++
 rtl/perf_counter_ctrl.sv | 112 +++++++++++
 2 files changed

// File: rtl/perf_counter_ctrl_if.sv
// MMIO request/response bundle for perf_counter_ctrl.
// master: read/write/address/wdata out, rdata/resp in; slave mirrors.
interface perf_counter_ctrl_if #(
  parameter int width = 32
);
  logic             mmio_read;
  logic             mmio_write;
  logic [3:0]       mmio_address;
  logic [width-1:0] mmio_wdata;
  logic [width-1:0] mmio_rdata;
  logic             mmio_resp;

  modport master (
    output mmio_read, mmio_write, mmio_address, mmio_wdata,
    input  mmio_rdata, mmio_resp
  );

  modport slave (
    input  mmio_read, mmio_write, mmio_address, mmio_wdata,
    output mmio_rdata, mmio_resp
  );
endinterface

// File: rtl/perf_counter_ctrl.sv
// Event counter bank with CTRL/OVF registers behind an MMIO handshake.
// Ports: clk, rst (sync high), events[NUM_CNT], mmio (slave modport).
module perf_counter_ctrl #(
  parameter int NUM_CNT = 8,
  parameter int width   = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_CNT-1:0] events,
  perf_counter_ctrl_if.slave mmio
);

  localparam logic [3:0] ADDR_CTRL = 4'd8;
  localparam logic [3:0] ADDR_OVF  = 4'd9;

  typedef enum logic {IDLE, RESP} state_t;

  state_t             state;
  logic [width-1:0]   cnt [NUM_CNT];
  logic [NUM_CNT-1:0] ovf;
  logic               en;

  logic               accept;
  logic               wr;
  logic               clear_all;
  logic [NUM_CNT-1:0] clr;
  logic [NUM_CNT-1:0] inc;
  logic [NUM_CNT-1:0] wrap;
  logic [NUM_CNT-1:0] w1c;
  logic [width-1:0]   rd_val;
  logic               unused_wdata;

  // Request lines are only looked at in IDLE, so a held request
  // is taken once per IDLE/RESP round trip.
  assign accept = (state == IDLE) &&
                  (mmio.mmio_read || mmio.mmio_write);
  assign wr = accept && mmio.mmio_write;

  assign clear_all = wr && (mmio.mmio_address == ADDR_CTRL) &&
                     mmio.mmio_wdata[1];

  assign w1c = (wr && mmio.mmio_address == ADDR_OVF) ?
               mmio.mmio_wdata[NUM_CNT-1:0] : '0;

  assign unused_wdata = ^mmio.mmio_wdata;

  // A clear suppresses the increment, so it can never wrap.
  always_comb begin
    clr  = '0;
    inc  = '0;
    wrap = '0;
    for (int i = 0; i < NUM_CNT; i++) begin
      clr[i]  = clear_all ||
                (wr && mmio.mmio_address == 4'(i));
      inc[i]  = en && events[i] && !clr[i];
      wrap[i] = inc[i] && (cnt[i] == '1);
    end
  end

  always_comb begin
    rd_val = '0;
    for (int i = 0; i < NUM_CNT; i++)
      if (mmio.mmio_address == 4'(i))
        rd_val = cnt[i];
    if (mmio.mmio_address == ADDR_CTRL)
      rd_val = width'(en);
    if (mmio.mmio_address == ADDR_OVF)
      rd_val = width'(ovf);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      mmio.mmio_resp  <= 1'b0;
      mmio.mmio_rdata <= '0;
      ovf             <= '0;
      en              <= 1'b0;
      for (int i = 0; i < NUM_CNT; i++)
        cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CNT; i++) begin
        if (clr[i])
          cnt[i] <= '0;
        else if (inc[i])
          cnt[i] <= cnt[i] + 1'b1;
      end
      // New overflow wins over a same-edge W1C.
      ovf <= (ovf & ~w1c) | wrap;
      if (wr && mmio.mmio_address == ADDR_CTRL)
        en <= mmio.mmio_wdata[0];
      case (state)
        IDLE: begin
          if (accept) begin
            state           <= RESP;
            mmio.mmio_resp  <= 1'b1;
            mmio.mmio_rdata <= mmio.mmio_write ? '0 : rd_val;
          end else begin
            mmio.mmio_resp  <= 1'b0;
            mmio.mmio_rdata <= '0;
          end
        end
        RESP: begin
          state           <= IDLE;
          mmio.mmio_resp  <= 1'b0;
          mmio.mmio_rdata <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
